// File: rtl/keypad_scan4x4.sv
// =============================================================================
//  Module   : keypad_scan4x4
//  Brief    : 4x4 matrix keypad scanner with press/release debounce and a
//             one-clock key_valid strobe. Optional auto-repeat: KEYPAD_REPEAT_EN.
//  Revision : 1.0 - initial release
// =============================================================================
`default_nettype none

module keypad_scan4x4 #(
    parameter int SCAN_DIV       = 200000,
    parameter int DEBOUNCE_SCANS = 4,
    parameter int REPEAT_TICKS   = 250
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [3:0] row_n,
    output logic [3:0] col_n,
    output logic [3:0] key_code,
    output logic       key_valid,
    output logic       key_held
);

    localparam int DIV_W = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
    localparam int CNT_W = $clog2(DEBOUNCE_SCANS + 1);
    localparam logic [DIV_W-1:0] C_DIV_LAST = DIV_W'(SCAN_DIV - 1);
    localparam logic [CNT_W-1:0] C_DEB_LAST = CNT_W'(DEBOUNCE_SCANS - 1);
    localparam bit               C_DEB_ONE  = (DEBOUNCE_SCANS == 1);

    localparam logic [1:0] S_SCAN      = 2'd0;
    localparam logic [1:0] S_DEB_PRESS = 2'd1;
    localparam logic [1:0] S_HELD      = 2'd2;
    localparam logic [1:0] S_DEB_REL   = 2'd3;

    logic [3:0]       r_row_s1;
    logic [3:0]       r_row_s2;
    logic [DIV_W-1:0] r_div;
    logic [1:0]       r_col_idx;
    logic [1:0]       r_state;
    logic [1:0]       w_state_next;
    logic [1:0]       r_cand_row;
    logic [1:0]       r_cand_col;
    logic [CNT_W-1:0] r_cnt;
    logic [3:0]       r_key_code;
    logic             r_key_valid;
    logic             r_key_held;

    logic       w_tick;
    logic       w_any_low;
    logic       w_cand_low;
    logic [1:0] w_low_row;
    logic       w_latch;
    logic       w_accept;
    logic       w_release;
    logic       w_advance;
    logic       w_cnt_start;
    logic       w_cnt_inc;
    logic [3:0] w_code_next;
    logic       w_rep_fire;

    // Out-of-range parameters elaborate this empty block; it has no hardware.
    if (SCAN_DIV < 2 || DEBOUNCE_SCANS < 1 || REPEAT_TICKS < 1) begin : g_bad_params
    end

    assign w_tick     = (r_div == C_DIV_LAST);
    assign w_any_low  = ~&r_row_s2;
    assign w_cand_low = ~r_row_s2[r_cand_row];

    // Lowest-numbered active row wins when several rows are pulled low.
    always_comb begin
        w_low_row = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (!r_row_s2[i]) w_low_row = 2'(i);
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_state <= S_SCAN;
        else     r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        if (w_tick) begin
            case (r_state)
                S_SCAN:      if (w_any_low)   w_state_next = C_DEB_ONE ? S_HELD : S_DEB_PRESS;
                S_DEB_PRESS: if (!w_cand_low) w_state_next = S_SCAN;
                             else if (r_cnt == C_DEB_LAST) w_state_next = S_HELD;
                S_HELD:      if (!w_cand_low) w_state_next = C_DEB_ONE ? S_SCAN : S_DEB_REL;
                S_DEB_REL:   if (w_cand_low)  w_state_next = S_HELD;
                             else if (r_cnt == C_DEB_LAST) w_state_next = S_SCAN;
                default:     w_state_next = S_SCAN;
            endcase
        end
    end

    always_comb begin
        w_latch     = w_tick && (r_state == S_SCAN) && w_any_low;
        w_accept    = w_tick && (w_state_next == S_HELD)
                      && ((r_state == S_SCAN) || (r_state == S_DEB_PRESS));
        w_release   = w_tick && (w_state_next == S_SCAN)
                      && ((r_state == S_HELD) || (r_state == S_DEB_REL));
        // Column only moves when the scanner is (back) in SCAN; it is frozen otherwise.
        w_advance   = w_tick && (w_state_next == S_SCAN);
        w_cnt_start = w_tick && (((r_state == S_SCAN) && w_any_low)
                                 || ((r_state == S_HELD) && !w_cand_low));
        w_cnt_inc   = w_tick && (((r_state == S_DEB_PRESS) && w_cand_low)
                                 || ((r_state == S_DEB_REL) && !w_cand_low));
        w_code_next = (r_state == S_SCAN) ? {w_low_row, r_col_idx} : {r_cand_row, r_cand_col};
    end

`ifdef KEYPAD_REPEAT_EN
    localparam int REP_W = $clog2(REPEAT_TICKS + 1);
    localparam logic [REP_W-1:0] C_REP_LAST = REP_W'(REPEAT_TICKS - 1);
    logic [REP_W-1:0] r_rep;

    assign w_rep_fire = w_tick && (r_state == S_HELD) && (w_state_next == S_HELD)
                        && (r_rep == C_REP_LAST);

    always_ff @(posedge clk) begin
        if (rst || (r_state != S_HELD) || (w_state_next != S_HELD)) r_rep <= '0;
        else if (w_rep_fire)                                        r_rep <= '0;
        else if (w_tick)                                            r_rep <= r_rep + 1'b1;
    end
`else
    assign w_rep_fire = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            r_row_s1    <= 4'b1111;
            r_row_s2    <= 4'b1111;
            r_div       <= '0;
            r_col_idx   <= 2'd0;
            r_cand_row  <= 2'd0;
            r_cand_col  <= 2'd0;
            r_cnt       <= '0;
            r_key_code  <= 4'd0;
            r_key_valid <= 1'b0;
            r_key_held  <= 1'b0;
        end else begin
            r_row_s1    <= row_n;
            r_row_s2    <= r_row_s1;
            r_div       <= w_tick ? '0 : r_div + 1'b1;
            r_key_valid <= w_accept || w_rep_fire;
            if (w_advance) r_col_idx <= r_col_idx + 1'b1;
            if (w_latch) begin
                r_cand_row <= w_low_row;
                r_cand_col <= r_col_idx;
            end
            if (w_cnt_start)    r_cnt <= CNT_W'(1);
            else if (w_cnt_inc) r_cnt <= r_cnt + 1'b1;
            if (w_accept)       r_key_code <= w_code_next;
            if (w_accept)       r_key_held <= 1'b1;
            else if (w_release) r_key_held <= 1'b0;
        end
    end

    assign col_n     = ~(4'b0001 << r_col_idx);
    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign key_held  = r_key_held;

endmodule

`default_nettype wire
